// File: rtl/fetch_stage.sv
// fetch_stage: 8-bit PC instruction fetch with a 2-entry queue feeding IF/ID.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [7:0]  PC,
  output logic [31:0] instruction,
  output logic        PC_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t      state, state_n;
  logic [7:0]  fetch_pc, fetch_pc_n, stale_addr, target;
  logic [7:0]  q_pc [2];
  logic [31:0] q_ins [2];
  logic [1:0]  count, count_n;
  logic        done, push, pop, slot;
  assign target      = redirect_pc & 8'hFC;
  assign imem_req    = state != IDLE;
  assign imem_addr   = state == DRAIN ? stale_addr : fetch_pc;
  assign done        = imem_req && imem_ready;
  assign PC_valid    = count != 2'd0;
  assign PC          = PC_valid ? q_pc[0] : 8'd0;
  assign instruction = PC_valid ? q_ins[0] : 32'd0;
  assign pop         = PC_valid && !stall && !redirect;
  assign push        = state == FETCH && done && !redirect;
  assign count_n     = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  // A push only happens with count<=1, so the free slot is count-pop.
  assign slot        = count[0] && !pop;
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect) fetch_pc_n = target;
        if (count_n < 2'd2) state_n = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          fetch_pc_n = target;
          state_n    = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready) begin
          fetch_pc_n = fetch_pc + 8'd4;
          state_n    = count_n < 2'd2 ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_n = target;
        if (imem_ready) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= 8'd0;
      stale_addr <= 8'd0;
      count      <= 2'd0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      count    <= count_n;
      if (state == FETCH && redirect && !imem_ready) stale_addr <= fetch_pc;
      if (pop) begin
        q_pc[0]  <= q_pc[1];
        q_ins[0] <= q_ins[1];
      end
      if (push) begin
        q_pc[slot]  <= fetch_pc;
        q_ins[slot] <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic against a queue-level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic        imem_req, PC_valid;
  logic [7:0]  imem_addr, PC;
  logic [31:0] imem_rdata, instruction;
  int          checks = 0, passed = 0;
  logic [39:0] q[$];
  logic [7:0]  fpc = 8'd0, saddr = 8'd0;
  bit          busy = 1'b0, stale = 1'b0;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PC(PC), .instruction(instruction), .PC_valid(PC_valid)
  );
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, 8'h5A, a ^ 8'hC3};
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  wire [49:0] dut_bus = {PC_valid, PC, instruction, imem_req, imem_addr};
  function automatic logic [49:0] exp_bus();
    return {q.size() != 0, q.size() != 0 ? q[0] : 40'd0, busy, stale ? saddr : fpc};
  endfunction
  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit done, pop, push;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); fpc = 8'd0; saddr = 8'd0; busy = 1'b0; stale = 1'b0;
    end else begin
      done = busy && imem_ready;
      pop  = q.size() != 0 && !stall && !redirect;
      push = done && !stale && !redirect;
      if (redirect) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back({fpc, mem_word(fpc)});
      end
      if (stale) begin
        if (done) stale = 1'b0;
      end else if (busy) begin
        if (redirect && !imem_ready) begin stale = 1'b1; saddr = fpc; end
        else if (!redirect && done) busy = q.size() < 2;
      end else busy = q.size() < 2;
      fpc = redirect ? (redirect_pc & 8'hFC) : push ? fpc + 8'd4 : fpc;
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    checks++; if (dut_bus !== 50'd0) $display("FAIL reset_outputs got %h exp 0", dut_bus); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if ({imem_req, imem_addr, PC_valid} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL first_req got %b/%h/%b exp 1/00/0", imem_req, imem_addr, PC_valid); else passed++;
  endtask
  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({PC_valid, PC, instruction} !== {1'b1, 8'(4 * i), mem_word(8'(4 * i))})
        $display("FAIL stream_pc%0d got %b/%h/%h exp 1/%h", i, PC_valid, PC, instruction, 8'(4 * i)); else passed++;
    end
  endtask
  task automatic test_stall();
    logic [7:0] hold;
    rst_n = 1'b0; tick(); rst_n = 1'b1; imem_ready = 1'b1; tick();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    hold = PC;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({PC_valid, PC} !== {1'b1, hold}) $display("FAIL stall_hold got %b/%h exp 1/%h", PC_valid, PC, hold); else passed++;
    end
    checks++; if (imem_req !== 1'b0 || dut_bus !== exp_bus()) $display("FAIL stall_full got %h exp %h", dut_bus, exp_bus()); else passed++;
    stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if ({PC_valid, PC} !== {1'b1, 8'(hold + 4 * k)})
        $display("FAIL stall_release got %b/%h exp 1/%h", PC_valid, PC, 8'(hold + 4 * k)); else passed++;
    end
  endtask
  task automatic test_latency();
    logic [7:0] a;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int r = 0; r < 4; r++) begin
      imem_ready = 1'b0;
      a = imem_addr;
      checks++; if (a !== 8'(4 * r)) $display("FAIL lat_addr got %h exp %h", a, 8'(4 * r)); else passed++;
      repeat (3) begin
        tick();
        checks++; if (dut_bus !== exp_bus() || imem_addr !== a || !imem_req)
          $display("FAIL lat_wait got %h exp %h", dut_bus, exp_bus()); else passed++;
      end
      imem_ready = 1'b1;
      tick();
      checks++; if ({PC_valid, PC} !== {1'b1, a} || dut_bus !== exp_bus())
        $display("FAIL lat_done got %h exp %h", dut_bus, exp_bus()); else passed++;
    end
  endtask
  task automatic test_redirect();
    bit found = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = imem_addr == 8'h10;
    end
    checks++; if (!found) $display("FAIL redir_reach got %h exp 10", imem_addr); else passed++;
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h41;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({PC_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h10})
        $display("FAIL redir_drain got %b/%b/%h exp 0/1/10", PC_valid, imem_req, imem_addr); else passed++;
      if (i < 2) tick();
    end
    imem_ready = 1'b1;
    tick();
    checks++; if ({PC_valid, imem_addr} !== {1'b0, 8'h40}) $display("FAIL redir_target got %b/%h exp 0/40", PC_valid, imem_addr); else passed++;
    tick();
    checks++; if ({PC_valid, PC, instruction} !== {1'b1, 8'h40, mem_word(8'h40)})
      $display("FAIL redir_first got %b/%h/%h exp 1/40", PC_valid, PC, instruction); else passed++;
  endtask
  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({PC_valid, PC} !== {1'b1, 8'(8'hF8 + 4 * i)})
        $display("FAIL wrap_pc got %b/%h exp 1/%h", PC_valid, PC, 8'(8'hF8 + 4 * i)); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    stall = 1'b1;
    repeat (3) tick();
    checks++; if ({PC_valid, imem_req} !== 2'b10 || dut_bus !== exp_bus())
      $display("FAIL mid_full got %h exp %h", dut_bus, exp_bus()); else passed++;
    rst_n = 1'b0;
    tick();
    checks++; if (dut_bus !== 50'd0) $display("FAIL mid_reset got %h exp 0", dut_bus); else passed++;
    rst_n = 1'b1; stall = 1'b0;
    tick();
    checks++; if ({imem_req, imem_addr, PC_valid} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL mid_restart got %b/%h/%b exp 1/00/0", imem_req, imem_addr, PC_valid); else passed++;
    tick();
    checks++; if ({PC_valid, PC} !== {1'b1, 8'h00}) $display("FAIL mid_first got %b/%h exp 1/00", PC_valid, PC); else passed++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      stall       = $urandom_range(0, 3) == 0;
      imem_ready  = $urandom_range(0, 2) != 0;
      redirect    = $urandom_range(0, 15) == 0;
      redirect_pc = 8'($urandom);
      rst_n       = $urandom_range(0, 199) != 0;
      tick();
      checks++; if (dut_bus !== exp_bus()) $display("FAIL random_c%0d got %h exp %h", i, dut_bus, exp_bus()); else passed++;
    end
    rst_n = 1'b1; redirect = 1'b0; stall = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
